// File: rtl/mib_pkg.sv
// Shared MIB slave types and bus widths.
package mib_pkg;
  localparam int MIB_AD_BITS   = 16;
  localparam int CMD_ADDR_BITS = 24;
  localparam int CMD_DATA_BITS = 32;
  localparam int MIB_MSN_HI    = 23;
  localparam int MIB_MSN_LO    = 20;

  typedef enum logic [3:0] {
    IDLE, ADDR2, WDAT1, WDAT2, CMD_REQ, CMD_WAIT, RD_HI, RD_LO, WR_ACK
  } mib_slv_state_t;
endpackage

// File: rtl/mib_ack_timer.sv
// Clearable, saturating command-ack timeout counter; o_expired fires on the
// cycle the count steps onto LIMIT and never again until cleared.
module mib_ack_timer #(
  parameter int LIMIT = 16
) (
  input  logic i_sysclk,
  input  logic i_srst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge i_sysclk) begin
    if (!i_srst_n || i_clr)
      cnt <= '0;
    else if (i_en && cnt != W'(LIMIT))
      cnt <= cnt + 1'b1;
  end

  assign o_expired = i_en && (cnt == W'(LIMIT - 1));
endmodule

// File: rtl/mib_cmd_slave.sv
// MIB slave endpoint: captures address/data phases, issues one command-bus
// transaction, returns ack or read data. Optional timeout error counter
// under `MIB_CMD_SLAVE_ERR_CNT_EN.
module mib_cmd_slave
  import mib_pkg::*;
#(
  parameter logic [3:0] P_MIB_MSN              = 4'h0,
  parameter int         P_CMD_ACK_TIMEOUT_CLKS = 16
) (
  input  logic                     i_sysclk,
  input  logic                     i_srst_n,
`ifdef MIB_CMD_SLAVE_ERR_CNT_EN
  input  logic                     i_err_cnt_clr,
  output logic [15:0]              o_err_cnt,
`endif
  input  logic                     i_mib_start,
  input  logic                     i_mib_rd_wr_n,
  input  logic [MIB_AD_BITS-1:0]   i_mib_ad,
  output logic [MIB_AD_BITS-1:0]   o_mib_ad,
  output logic                     o_mib_ad_high_z,
  output logic                     o_mib_slave_ack,
  output logic                     o_cmd_sel,
  output logic                     o_cmd_rd_wr_n,
  output logic [CMD_ADDR_BITS-1:0] o_cmd_byte_addr,
  output logic [CMD_DATA_BITS-1:0] o_cmd_wdata,
  input  logic                     i_cmd_ack,
  input  logic [CMD_DATA_BITS-1:0] i_cmd_rdata,
  output logic                     o_cmd_timeout
);
  mib_slv_state_t state, nxt;
  logic tmo_nxt, expired;
  logic [MIB_AD_BITS-1:0] rd_lo;

  mib_ack_timer #(.LIMIT(P_CMD_ACK_TIMEOUT_CLKS)) u_timer (
    .i_sysclk  (i_sysclk),
    .i_srst_n  (i_srst_n),
    .i_clr     (nxt == CMD_REQ),
    .i_en      (state == CMD_REQ || state == CMD_WAIT),
    .o_expired (expired)
  );

  always_ff @(posedge i_sysclk) begin
    if (!i_srst_n) state <= IDLE;
    else           state <= nxt;
  end

  always_comb begin
    nxt     = state;
    tmo_nxt = 1'b0;
    case (state)
      IDLE:   if (i_mib_start) nxt = ADDR2;
      ADDR2:  if (o_cmd_byte_addr[MIB_MSN_HI:MIB_MSN_LO] != P_MIB_MSN) nxt = IDLE;
              else nxt = o_cmd_rd_wr_n ? CMD_REQ : WDAT1;
      WDAT1:  nxt = WDAT2;
      WDAT2:  nxt = CMD_REQ;
      // ack may already arrive in the request cycle itself
      CMD_REQ, CMD_WAIT: begin
        if (i_cmd_ack)    nxt = o_cmd_rd_wr_n ? RD_HI : WR_ACK;
        else if (expired) begin nxt = IDLE; tmo_nxt = 1'b1; end
        else              nxt = CMD_WAIT;
      end
      RD_HI:  nxt = RD_LO;
      RD_LO:  nxt = IDLE;
      WR_ACK: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered from next-state so pads change only on edges.
  always_ff @(posedge i_sysclk) begin
    if (!i_srst_n) begin
      o_mib_ad        <= '0;
      o_mib_ad_high_z <= 1'b1;
      o_mib_slave_ack <= 1'b0;
      o_cmd_sel       <= 1'b0;
      o_cmd_rd_wr_n   <= 1'b1;
      o_cmd_byte_addr <= '0;
      o_cmd_wdata     <= '0;
      o_cmd_timeout   <= 1'b0;
      rd_lo           <= '0;
    end else begin
      o_cmd_sel       <= (nxt == CMD_REQ);
      o_cmd_timeout   <= tmo_nxt;
      o_mib_slave_ack <= (nxt inside {RD_HI, RD_LO, WR_ACK});
      o_mib_ad_high_z <= !(nxt inside {RD_HI, RD_LO});
      o_mib_ad        <= '0;
      if (state == IDLE && i_mib_start) begin
        o_cmd_rd_wr_n          <= i_mib_rd_wr_n;
        o_cmd_byte_addr[23:16] <= i_mib_ad[7:0];
      end
      if (state == ADDR2) o_cmd_byte_addr[15:0] <= i_mib_ad;
      if (state == WDAT1) o_cmd_wdata[31:16]    <= i_mib_ad;
      if (state == WDAT2) o_cmd_wdata[15:0]     <= i_mib_ad;
      if (nxt == RD_HI) begin
        o_mib_ad <= i_cmd_rdata[31:16];
        rd_lo    <= i_cmd_rdata[15:0];
      end
      if (nxt == RD_LO) o_mib_ad <= rd_lo;
    end
  end

`ifdef MIB_CMD_SLAVE_ERR_CNT_EN
  always_ff @(posedge i_sysclk) begin
    if (!i_srst_n || i_err_cnt_clr)
      o_err_cnt <= '0;
    else if (o_cmd_timeout && o_err_cnt != 16'hFFFF)
      o_err_cnt <= o_err_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_mib_cmd_slave.sv
// Directed bench for mib_cmd_slave: write/read hits, miss, timeout, reset, back to back.
`timescale 1ns/1ps
module tb_mib_cmd_slave;
  logic        clk = 1'b0;
  logic        srst_n, mib_start, mib_rd_wr_n, cmd_ack;
  logic [15:0] mib_ad_in, mib_ad;
  logic        mib_ad_high_z, mib_slave_ack, cmd_sel, cmd_rd_wr_n, cmd_timeout;
  logic [23:0] cmd_byte_addr;
  logic [31:0] cmd_wdata, cmd_rdata;
`ifdef MIB_CMD_SLAVE_ERR_CNT_EN
  logic        err_cnt_clr;
  logic [15:0] err_cnt;
`endif

  int n_pass = 0, n_tot = 0;
  int n_ack, n_drv, n_sel, n_tmo;

  always #5 clk = ~clk;

  mib_cmd_slave #(.P_MIB_MSN(4'h0), .P_CMD_ACK_TIMEOUT_CLKS(16)) dut (
    .i_sysclk        (clk),
    .i_srst_n        (srst_n),
`ifdef MIB_CMD_SLAVE_ERR_CNT_EN
    .i_err_cnt_clr   (err_cnt_clr),
    .o_err_cnt       (err_cnt),
`endif
    .i_mib_start     (mib_start),
    .i_mib_rd_wr_n   (mib_rd_wr_n),
    .i_mib_ad        (mib_ad_in),
    .o_mib_ad        (mib_ad),
    .o_mib_ad_high_z (mib_ad_high_z),
    .o_mib_slave_ack (mib_slave_ack),
    .o_cmd_sel       (cmd_sel),
    .o_cmd_rd_wr_n   (cmd_rd_wr_n),
    .o_cmd_byte_addr (cmd_byte_addr),
    .o_cmd_wdata     (cmd_wdata),
    .i_cmd_ack       (cmd_ack),
    .i_cmd_rdata     (cmd_rdata),
    .o_cmd_timeout   (cmd_timeout)
  );

  // One clock: inputs set before the call are sampled on the posedge,
  // outputs are observed on the following negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (mib_slave_ack)  n_ack++;
    if (!mib_ad_high_z) n_drv++;
    if (cmd_sel)        n_sel++;
    if (cmd_timeout)    n_tmo++;
  endtask

  task automatic clr_counts();
    n_ack = 0; n_drv = 0; n_sel = 0; n_tmo = 0;
  endtask

  // Drives A1, A2 (and W1, W2 for writes); returns observing the CMD_REQ cycle on a hit.
  task automatic mib_issue(input logic rd, input logic [23:0] a, input logic [31:0] d);
    mib_start = 1'b1; mib_rd_wr_n = rd; mib_ad_in = {8'h00, a[23:16]}; step();
    mib_start = 1'b0; mib_ad_in = a[15:0]; step();
    if (!rd) begin
      mib_ad_in = d[31:16]; step();
      mib_ad_in = d[15:0];  step();
    end
    mib_ad_in = 16'h0000;
  endtask

  task automatic test_reset();
    srst_n = 1'b0; step(); step();
    n_tot++; if (mib_ad_high_z !== 1'b1) $display("FAIL rst_high_z got %0b want 1", mib_ad_high_z); else n_pass++;
    n_tot++; if (mib_ad !== 16'h0) $display("FAIL rst_mib_ad got %h want 0000", mib_ad); else n_pass++;
    n_tot++; if (mib_slave_ack !== 1'b0) $display("FAIL rst_ack got %0b want 0", mib_slave_ack); else n_pass++;
    n_tot++; if (cmd_sel !== 1'b0) $display("FAIL rst_sel got %0b want 0", cmd_sel); else n_pass++;
    n_tot++; if (cmd_rd_wr_n !== 1'b1) $display("FAIL rst_rd_wr_n got %0b want 1", cmd_rd_wr_n); else n_pass++;
    n_tot++; if (cmd_byte_addr !== 24'h0) $display("FAIL rst_addr got %h want 000000", cmd_byte_addr); else n_pass++;
    n_tot++; if (cmd_wdata !== 32'h0) $display("FAIL rst_wdata got %h want 00000000", cmd_wdata); else n_pass++;
    n_tot++; if (cmd_timeout !== 1'b0) $display("FAIL rst_timeout got %0b want 0", cmd_timeout); else n_pass++;
`ifdef MIB_CMD_SLAVE_ERR_CNT_EN
    n_tot++; if (err_cnt !== 16'h0) $display("FAIL rst_err_cnt got %0d want 0", err_cnt); else n_pass++;
`endif
    srst_n = 1'b1; step();
  endtask

  task automatic test_write_hit();
    clr_counts();
    mib_issue(1'b0, 24'h000004, 32'h01010202);
    n_tot++; if (cmd_sel !== 1'b1) $display("FAIL wr_sel_cycle4 got %0b want 1", cmd_sel); else n_pass++;
    n_tot++; if (cmd_byte_addr !== 24'h000004) $display("FAIL wr_addr got %h want 000004", cmd_byte_addr); else n_pass++;
    n_tot++; if (cmd_wdata !== 32'h01010202) $display("FAIL wr_wdata got %h want 01010202", cmd_wdata); else n_pass++;
    n_tot++; if (cmd_rd_wr_n !== 1'b0) $display("FAIL wr_dir got %0b want 0", cmd_rd_wr_n); else n_pass++;
    step(); step(); step();
    cmd_ack = 1'b1; step(); cmd_ack = 1'b0;
    n_tot++; if (mib_slave_ack !== 1'b1) $display("FAIL wr_ack_timing got %0b want 1", mib_slave_ack); else n_pass++;
    step(); step(); step();
    n_tot++; if (n_ack !== 1) $display("FAIL wr_ack_count got %0d want 1", n_ack); else n_pass++;
    n_tot++; if (n_sel !== 1) $display("FAIL wr_sel_count got %0d want 1", n_sel); else n_pass++;
    n_tot++; if (n_drv !== 0) $display("FAIL wr_bus_driven got %0d want 0", n_drv); else n_pass++;
  endtask

  task automatic test_read_hit();
    clr_counts();
    mib_issue(1'b1, 24'h000008, 32'h0);
    n_tot++; if (cmd_sel !== 1'b1) $display("FAIL rd_sel_cycle2 got %0b want 1", cmd_sel); else n_pass++;
    n_tot++; if (cmd_byte_addr !== 24'h000008) $display("FAIL rd_addr got %h want 000008", cmd_byte_addr); else n_pass++;
    n_tot++; if (cmd_rd_wr_n !== 1'b1) $display("FAIL rd_dir got %0b want 1", cmd_rd_wr_n); else n_pass++;
    step();
    cmd_ack = 1'b1; cmd_rdata = 32'hDEADBEEF; step();
    cmd_ack = 1'b0; cmd_rdata = 32'h0;
    n_tot++; if (mib_ad !== 16'hDEAD) $display("FAIL rd_hi_data got %h want DEAD", mib_ad); else n_pass++;
    n_tot++; if (mib_ad_high_z !== 1'b0) $display("FAIL rd_hi_high_z got %0b want 0", mib_ad_high_z); else n_pass++;
    n_tot++; if (mib_slave_ack !== 1'b1) $display("FAIL rd_hi_ack got %0b want 1", mib_slave_ack); else n_pass++;
    step();
    n_tot++; if (mib_ad !== 16'hBEEF) $display("FAIL rd_lo_data got %h want BEEF", mib_ad); else n_pass++;
    n_tot++; if (mib_slave_ack !== 1'b1) $display("FAIL rd_lo_ack got %0b want 1", mib_slave_ack); else n_pass++;
    step();
    n_tot++; if (mib_ad_high_z !== 1'b1) $display("FAIL rd_release got %0b want 1", mib_ad_high_z); else n_pass++;
    step();
    n_tot++; if (n_drv !== 2) $display("FAIL rd_drive_cycles got %0d want 2", n_drv); else n_pass++;
    n_tot++; if (n_ack !== 2) $display("FAIL rd_ack_cycles got %0d want 2", n_ack); else n_pass++;
  endtask

  task automatic test_addr_miss();
    clr_counts();
    mib_issue(1'b0, 24'h100004, 32'hA5A5A5A5);
    for (int i = 0; i < 6; i++) step();
    n_tot++; if (n_sel !== 0) $display("FAIL miss_sel got %0d want 0", n_sel); else n_pass++;
    n_tot++; if (n_ack !== 0) $display("FAIL miss_ack got %0d want 0", n_ack); else n_pass++;
    n_tot++; if (n_drv !== 0) $display("FAIL miss_drive got %0d want 0", n_drv); else n_pass++;
  endtask

  task automatic test_timeout();
    int k;
    clr_counts();
    mib_issue(1'b1, 24'h000000, 32'h0);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (cmd_timeout) begin k = i; break; end
    end
    n_tot++; if (k != 16) $display("FAIL tmo_latency got %0d want 16", k); else n_pass++;
    step();
    n_tot++; if (cmd_timeout !== 1'b0) $display("FAIL tmo_pulse_width got %0b want 0", cmd_timeout); else n_pass++;
`ifdef MIB_CMD_SLAVE_ERR_CNT_EN
    n_tot++; if (err_cnt !== 16'd1) $display("FAIL tmo_err_cnt got %0d want 1", err_cnt); else n_pass++;
    err_cnt_clr = 1'b1; step(); err_cnt_clr = 1'b0;
    n_tot++; if (err_cnt !== 16'd0) $display("FAIL err_cnt_clear got %0d want 0", err_cnt); else n_pass++;
`endif
    // a late ack while idle must not produce a MIB ack
    cmd_ack = 1'b1; step(); cmd_ack = 1'b0;
    step(); step();
    n_tot++; if (n_ack !== 0) $display("FAIL tmo_no_mib_ack got %0d want 0", n_ack); else n_pass++;
    n_tot++; if (n_drv !== 0) $display("FAIL tmo_no_drive got %0d want 0", n_drv); else n_pass++;
    n_tot++; if (n_tmo !== 1) $display("FAIL tmo_count got %0d want 1", n_tmo); else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    clr_counts();
    mib_issue(1'b1, 24'h000010, 32'h0);
    step();
    srst_n = 1'b0; step();
    n_tot++; if (mib_ad_high_z !== 1'b1) $display("FAIL mid_rst_high_z got %0b want 1", mib_ad_high_z); else n_pass++;
    n_tot++; if (cmd_rd_wr_n !== 1'b1) $display("FAIL mid_rst_dir got %0b want 1", cmd_rd_wr_n); else n_pass++;
    n_tot++; if (cmd_byte_addr !== 24'h0) $display("FAIL mid_rst_addr got %h want 000000", cmd_byte_addr); else n_pass++;
    n_tot++; if (cmd_wdata !== 32'h0) $display("FAIL mid_rst_wdata got %h want 00000000", cmd_wdata); else n_pass++;
    n_tot++; if (cmd_sel !== 1'b0 || mib_slave_ack !== 1'b0 || cmd_timeout !== 1'b0 || mib_ad !== 16'h0)
      $display("FAIL mid_rst_pulses got sel=%0b ack=%0b tmo=%0b ad=%h want all 0", cmd_sel, mib_slave_ack, cmd_timeout, mib_ad);
    else n_pass++;
    srst_n = 1'b1; step();
    clr_counts();
    mib_issue(1'b0, 24'h000020, 32'hCAFEF00D);
    n_tot++; if (cmd_sel !== 1'b1 || cmd_wdata !== 32'hCAFEF00D) $display("FAIL post_rst_wr got sel=%0b wdata=%h want 1 CAFEF00D", cmd_sel, cmd_wdata); else n_pass++;
    cmd_ack = 1'b1; step(); cmd_ack = 1'b0;
    n_tot++; if (mib_slave_ack !== 1'b1) $display("FAIL post_rst_ack got %0b want 1", mib_slave_ack); else n_pass++;
    for (int i = 0; i < 20; i++) step();
    n_tot++; if (n_tmo !== 0 || n_ack !== 1) $display("FAIL post_rst_quiet got tmo=%0d ack=%0d want 0 1", n_tmo, n_ack); else n_pass++;
  endtask

  task automatic test_back_to_back();
    clr_counts();
    mib_issue(1'b0, 24'h000030, 32'h11223344);
    step();
    cmd_ack = 1'b1; step(); cmd_ack = 1'b0;
    n_tot++; if (mib_slave_ack !== 1'b1) $display("FAIL b2b_wr_ack got %0b want 1", mib_slave_ack); else n_pass++;
    step();
    mib_issue(1'b1, 24'h000034, 32'h0);
    step();
    // stray start while waiting on the command bus
    mib_start = 1'b1; mib_rd_wr_n = 1'b0; mib_ad_in = 16'h00FF; step();
    mib_start = 1'b0; mib_ad_in = 16'h0000;
    cmd_ack = 1'b1; cmd_rdata = 32'h55667788; step();
    cmd_ack = 1'b0; cmd_rdata = 32'h0;
    n_tot++; if (mib_ad !== 16'h5566) $display("FAIL b2b_rd_hi got %h want 5566", mib_ad); else n_pass++;
    step();
    n_tot++; if (mib_ad !== 16'h7788) $display("FAIL b2b_rd_lo got %h want 7788", mib_ad); else n_pass++;
    step();
    n_tot++; if (cmd_byte_addr !== 24'h000034 || cmd_rd_wr_n !== 1'b1)
      $display("FAIL b2b_stray_start got addr=%h dir=%0b want 000034 1", cmd_byte_addr, cmd_rd_wr_n);
    else n_pass++;
    for (int i = 0; i < 4; i++) step();
    n_tot++; if (n_sel !== 2) $display("FAIL b2b_sel_count got %0d want 2", n_sel); else n_pass++;
    n_tot++; if (n_ack !== 3) $display("FAIL b2b_ack_count got %0d want 3", n_ack); else n_pass++;
    n_tot++; if (n_drv !== 2) $display("FAIL b2b_drive_count got %0d want 2", n_drv); else n_pass++;
  endtask

  initial begin
    srst_n = 1'b0; mib_start = 1'b0; mib_rd_wr_n = 1'b0; mib_ad_in = 16'h0;
    cmd_ack = 1'b0; cmd_rdata = 32'h0;
`ifdef MIB_CMD_SLAVE_ERR_CNT_EN
    err_cnt_clr = 1'b0;
`endif
    clr_counts();
    test_reset();
    test_write_hit();
    test_read_hit();
    test_addr_miss();
    test_timeout();
    test_reset_mid_read();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/mib_cmd_slave.md
# mib_cmd_slave

Per-FPGA MIB slave endpoint: directly downstream of the MIB master on the shared 16-bit MIB bus. Captures the two address phases and, for writes, the two data phases, then filters on the address nibble. It issues a single 32-bit command-bus transaction to the local register space and returns a write ack or two read-data phases to the master. One instance sits at each FPGA top, between the registered MIB pads and the local command-bus fabric.

## Interface

- P_MIB_MSN, 4'h0: address nibble `addr[23:20]` this slave answers to.
- P_CMD_ACK_TIMEOUT_CLKS, 16: clocks to wait for `i_cmd_ack` before abandoning the transaction.
- i_sysclk, in, 1: the single clock for the MIB and command sides.
- i_srst_n, in, 1: reset, synchronous, active-low.
- i_mib_start, in, 1: master start pulse, high for exactly one cycle during address phase A1.
- i_mib_rd_wr_n, in, 1: 1 = read, 0 = write; sampled together with `i_mib_start`.
- i_mib_ad, in, 16: registered input from the MIB pads.
- o_mib_ad, out, 16: read data driven toward the pads.
- o_mib_ad_high_z, out, 1: 1 = tri-state the pad; 0 = drive `o_mib_ad`.
- o_mib_slave_ack, out, 1: write ack, or read-data-valid.
- o_cmd_sel, out, 1: command request pulse, one cycle long.
- o_cmd_rd_wr_n, out, 1: command direction.
- o_cmd_byte_addr, out, 24: command address.
- o_cmd_wdata, out, 32: command write data.
- i_cmd_ack, in, 1: command completion; for reads, `i_cmd_rdata` is valid in the same cycle.
- i_cmd_rdata, in, 32: command read data.
- o_cmd_timeout, out, 1: one-cycle pulse when `P_CMD_ACK_TIMEOUT_CLKS` expires.

## Operation

MIB phases, one cycle each and back to back:
- A1: `i_mib_start`=1, `i_mib_ad`={8'h00, addr[23:16]}.
- A2: `i_mib_ad`=addr[15:0].
- Writes only: W1 carries wdata[31:16], W2 carries wdata[15:0].

States: IDLE, ADDR2, WDAT1, WDAT2, CMD_REQ, CMD_WAIT, RD_HI, RD_LO, WR_ACK.

- **IDLE**
  - On `i_mib_start`, latch `addr[23:16]` and `rd_wr_n`, then go to ADDR2.
  - `i_mib_start` in any other state is ignored.
- **ADDR2**
  - Latch `addr[15:0]`.
  - If `addr[23:20]` != `P_MIB_MSN`: go to IDLE. For a write, the W1/W2 cycles that follow are not captured. The bus is never driven.
  - Otherwise a write goes to WDAT1 and a read goes to CMD_REQ.
- **WDAT1, WDAT2**: latch the data halves; WDAT2 goes to CMD_REQ.
- **CMD_REQ**
  - Hold `o_cmd_sel`=1 for one cycle with address, direction and data valid.
  - Clear the timeout counter; go to CMD_WAIT.
  - Address, direction and data stay stable until the state returns to IDLE.
- **CMD_WAIT**
  - On `i_cmd_ack`: a read latches `i_cmd_rdata` and goes to RD_HI; a write goes to WR_ACK.
  - `i_cmd_ack` in the CMD_REQ cycle itself is also accepted.
  - When the counter reaches `P_CMD_ACK_TIMEOUT_CLKS` with no ack: pulse `o_cmd_timeout` and go to IDLE. No MIB ack is given; the master times out on its side.
- **RD_HI**: `o_mib_ad_high_z`=0, `o_mib_ad`=rdata[31:16], `o_mib_slave_ack`=1.
- **RD_LO**: same outputs with `o_mib_ad`=rdata[15:0]; then go to IDLE.
- **WR_ACK**: `o_mib_slave_ack`=1 for one cycle; then go to IDLE.
- **Late ack**: an `i_cmd_ack` arriving in IDLE is ignored.

## Timing

- **Reset values** (`i_srst_n`=0, sampled at the clock edge):
  - state=IDLE.
  - `o_mib_ad_high_z`=1, `o_mib_ad`=0, `o_mib_slave_ack`=0.
  - `o_cmd_sel`=0, `o_cmd_rd_wr_n`=1, `o_cmd_byte_addr`=0, `o_cmd_wdata`=0.
  - `o_cmd_timeout`=0.
  - Reset mid-transaction aborts it with no ack. The bus is released on the next edge.
- **Write latency**: A1 at cycle 0, `o_cmd_sel` at cycle 4, `o_mib_slave_ack` one cycle after `i_cmd_ack` is sampled.
- **Read latency**: A1 at cycle 0, `o_cmd_sel` at cycle 2, RD_HI one cycle after `i_cmd_ack`, RD_LO the cycle after that.
- **Bus ownership**: `o_mib_ad_high_z`=0 only in RD_HI and RD_LO, and all outputs are registered. The slave therefore never drives during the master's A or W phases.
- **Timeout counter**: `$clog2(P_CMD_ACK_TIMEOUT_CLKS+1)` bits wide and never wraps.

## Configuration

- Macro `MIB_CMD_SLAVE_ERR_CNT_EN`.
- **Defined**:
  - Adds output `o_err_cnt[15:0]` and input `i_err_cnt_clr`.
  - The counter increments on each `o_cmd_timeout` and saturates at 16'hFFFF.
  - It clears to 0 on reset or on `i_err_cnt_clr`; a clear in the same cycle as a timeout wins.
- **Undefined**: neither port exists and the counter logic is absent. All other behaviour is identical.

## Structure

- **Shared package `mib_pkg`**:
  - State enum `mib_slv_state_t`.
  - `MIB_AD_BITS`=16, `CMD_ADDR_BITS`=24, `CMD_DATA_BITS`=32.
  - `MIB_MSN_HI`=23, `MIB_MSN_LO`=20.
- **Sub-module**: one, `mib_ack_timer`. It is the clearable, saturating timeout counter, parameterised by limit, with a one-cycle `o_expired` pulse.

## Test plan

- **Write hit**: with `P_MIB_MSN`=0, write 0x000004 ← 0x01010202, `i_cmd_ack` after 3 cycles. Expect `o_cmd_byte_addr`=0x000004 and `o_cmd_wdata`=0x01010202, then a single `o_mib_slave_ack` one cycle after the ack.
- **Read hit**: read 0x000008 with `i_cmd_rdata`=0xDEADBEEF. Expect RD_HI drives 0xDEAD and RD_LO drives 0xBEEF, both with ack; high_z=0 exactly those 2 cycles.
- **Address miss**: write to 0x100004. Expect no `o_cmd_sel`, no ack, and high_z stays 1 throughout.
- **Command timeout**: read 0x000000 and never assert `i_cmd_ack`. Expect `o_cmd_timeout` pulses 16 cycles after `o_cmd_sel`, then IDLE with no MIB ack. With the macro defined, `o_err_cnt`=1.
- **Reset mid-read**: assert `i_srst_n`=0 during CMD_WAIT. Expect all outputs at their reset values on the next edge, and a following write completes normally.
- **Back to back**: issue a write then a read with one idle cycle between them. Expect both to complete, and a stray `i_mib_start` during CMD_WAIT is ignored.
